gol_ctrl: RTL

GOL_CTRL -- requirements
Module: gol_ctrl

---
 rtl/gol_pkg.sv | 20 ++
 rtl/gol_next.sv | 45 ++++
 rtl/gol_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// Shared types and constants for the 8x8 Game of Life controller.
package gol_pkg;

  localparam int GRID_N = 8;
  localparam int CELLS  = GRID_N * GRID_N;

  typedef logic [CELLS-1:0] grid_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  function automatic int cell_idx(input int r, input int c);
    return r * GRID_N + c;
  endfunction

endpackage

// File: rtl/gol_next.sv
// Combinational B3/S23 next-generation logic for an 8x8 grid with dead borders.
module gol_next
  import gol_pkg::*;
(
  input  grid_t grid_i,
  output grid_t next_o
);

  // A ring of permanently dead cells removes every edge special case.
  localparam int PN = GRID_N + 2;

  logic [PN*PN-1:0] padded;

  always_comb begin
    padded = '0;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        padded[(r + 1) * PN + c + 1] = grid_i[cell_idx(r, c)];
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < CELLS; gi++) begin : g_cell
    localparam int R = gi / GRID_N;
    localparam int C = gi % GRID_N;
    localparam int P = (R + 1) * PN + C + 1;

    logic [3:0] cnt;

    always_comb begin
      cnt = '0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (dr != 0 || dc != 0) begin
            cnt = cnt + 4'(padded[P + dr * PN + dc]);
          end
        end
      end
    end

    assign next_o[gi] = (cnt == 4'd3) || ((cnt == 4'd2) && grid_i[gi]);
  end

endmodule

// File: rtl/gol_ctrl.sv
// Game of Life run controller: seed load, tick-divided stepping, pause and
// termination on still life, extinction or generation limit.
module gol_ctrl
  import gol_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic [63:0] seed,
  input  logic [7:0]  gen_limit,
  output logic [63:0] grid,
  output logic [7:0]  gen_count,
  output logic        busy,
  output logic        done,
  output logic        still,
  output logic        extinct
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t          state_q, state_d;
  grid_t           grid_q, grid_d;
  logic [7:0]      gen_q, gen_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            still_q, still_d;
  logic            extinct_q, extinct_d;

  grid_t           next_grid;
  logic [7:0]      gen_inc;

  gol_next u_next (
    .grid_i (grid_q),
    .next_o (next_grid)
  );

  assign gen_inc = gen_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      tick_q    <= '0;
      still_q   <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      tick_q    <= tick_d;
      still_q   <= still_d;
      extinct_q <= extinct_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    tick_d    = tick_q;
    still_d   = still_q;
    extinct_d = extinct_q;

    if (start) begin
      // Reload wins in every state, including a restart from RUN.
      state_d   = ST_RUN;
      grid_d    = seed;
      gen_d     = '0;
      tick_d    = '0;
      still_d   = 1'b0;
      extinct_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            // An empty grid is its own successor, so it lands in the still branch.
            if (next_grid == grid_q) begin
              still_d = 1'b1;
              state_d = ST_DONE;
            end else if (next_grid == '0) begin
              grid_d    = '0;
              gen_d     = gen_inc;
              extinct_d = 1'b1;
              state_d   = ST_DONE;
            end else begin
              grid_d = next_grid;
              gen_d  = gen_inc;
              if (gen_limit != 8'd0 && gen_inc == gen_limit) begin
                state_d = ST_DONE;
              end
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    done      = (state_q == ST_DONE);
    grid      = grid_q;
    gen_count = gen_q;
    still     = still_q;
    extinct   = extinct_q;
  end

endmodule
